// File: rtl/bch_encode.sv
// bch_encode: serial systematic BCH encoder, message bits then parity bits, MSB first
module bch_encode #(
   parameter int DATA_BITS = 5,
   parameter int PARITY_BITS = 10,
   parameter logic [PARITY_BITS-1:0] GEN_POLY = 10'h137
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic start,
   input  logic data_in,
   output logic accept,
   output logic data_out,
   output logic data_out_valid,
   output logic parity_out,
   output logic done
);
   localparam int MX = DATA_BITS > PARITY_BITS ? DATA_BITS : PARITY_BITS;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
   state_t state, state_nx;
   logic [PARITY_BITS-1:0] lfsr, lfsr_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic dout_nx, valid_nx, par_nx, done_nx, fb, last;
   assign accept = state == DATA;
   // next-state, LFSR division step and output bit selection
   always_comb begin
      fb = data_in ^ lfsr[PARITY_BITS-1];
      last = 1'b0;
      state_nx = state;
      lfsr_nx = lfsr;
      cnt_nx = cnt;
      dout_nx = data_out;
      valid_nx = 1'b0;
      par_nx = parity_out;
      done_nx = 1'b0;
      if (start) begin
         state_nx = DATA_BITS == 1 ? PARITY : DATA;
         lfsr_nx = GEN_POLY & {PARITY_BITS{data_in}};
         cnt_nx = DATA_BITS == 1 ? '0 : CW'(1);
         dout_nx = data_in;
         valid_nx = 1'b1;
         par_nx = 1'b0;
      end else if (state == DATA) begin
         last = cnt == CW'(DATA_BITS - 1);
         state_nx = last ? PARITY : DATA;
         lfsr_nx = (lfsr << 1) ^ (GEN_POLY & {PARITY_BITS{fb}});
         cnt_nx = last ? '0 : cnt + CW'(1);
         dout_nx = data_in;
         valid_nx = 1'b1;
         par_nx = 1'b0;
      end else if (state == PARITY) begin
         last = cnt == CW'(PARITY_BITS - 1);
         state_nx = last ? IDLE : PARITY;
         lfsr_nx = lfsr << 1;
         cnt_nx = last ? '0 : cnt + CW'(1);
         dout_nx = lfsr[PARITY_BITS-1];
         valid_nx = 1'b1;
         par_nx = 1'b1;
         done_nx = last;
      end
   end
   // state and output registers; strobes clear whenever ce is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lfsr <= '0;
         cnt <= '0;
         data_out <= 1'b0;
         data_out_valid <= 1'b0;
         parity_out <= 1'b0;
         done <= 1'b0;
      end else if (ce) begin
         state <= state_nx;
         lfsr <= lfsr_nx;
         cnt <= cnt_nx;
         data_out <= dout_nx;
         data_out_valid <= valid_nx;
         parity_out <= par_nx;
         done <= done_nx;
      end else begin
         data_out_valid <= 1'b0;
         done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bch_encode.sv
// tb_bch_encode: directed self-checking bench for bch_encode (BCH(15,5) defaults)
module tb_bch_encode;
   logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, start = 1'b0, data_in = 1'b0;
   logic accept, data_out, data_out_valid, parity_out, done;
   int n_cmp = 0, n_bad = 0;
   logic [14:0] cw, am, pm, dm;
   int nv, gerr;
   logic [4:0] msg;

   always #5 clk = ~clk;

   bch_encode dut (
      .clk(clk),
      .rst_n(rst_n),
      .ce(ce),
      .start(start),
      .data_in(data_in),
      .accept(accept),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .parity_out(parity_out),
      .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // remainder of a 15-bit word by g(x) = x^10+x^8+x^5+x^4+x^2+x+1 (0x537)
   function automatic logic [9:0] mod15(input logic [14:0] w);
      for (int i = 14; i >= 10; i--)
         if (w[i]) w = w ^ (15'h537 << (i - 10));
      return w[9:0];
   endfunction

   // issue n codeword ce cycles (first with start), optionally with random ce gaps
   task automatic run_cw(input logic [4:0] m, input bit gaps, input int n,
                         output logic [14:0] c, output logic [14:0] a,
                         output logic [14:0] p, output logic [14:0] d,
                         output int v, output int ge);
      c = '0; a = '0; p = '0; d = '0; v = 0; ge = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps)
            for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
               ce = 1'b0; start = 1'($urandom); data_in = 1'($urandom);
               @(posedge clk); #1;
               if (data_out_valid || done) ge++;
            end
         ce = 1'b1;
         start = i == 0;
         data_in = i < 5 ? m[4 - i] : 1'($urandom);
         a = {a[13:0], accept};
         @(posedge clk); #1;
         c = {c[13:0], data_out};
         p = {p[13:0], parity_out};
         d = {d[13:0], done};
         v += int'(data_out_valid);
      end
      ce = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      // reset state
      @(posedge clk); #1;
      check("reset_outputs", {accept, data_out, data_out_valid, parity_out, done}, 0);
      rst_n = 1'b1;
      // message 00001: parity 0x137
      run_cw(5'b00001, 0, 15, cw, am, pm, dm, nv, gerr);
      check("m1_codeword", cw, 15'h0537);
      check("m1_parity_flag", pm, 15'h03ff);
      check("m1_done", dm, 15'h0001);
      check("m1_accept", am, 15'h3c00);
      check("m1_valid_count", nv, 15);
      // message 10000 immediately back-to-back: parity 0x29B
      run_cw(5'b10000, 0, 15, cw, am, pm, dm, nv, gerr);
      check("m2_codeword", cw, 15'h429b);
      check("m2_done", dm, 15'h0001);
      check("m2_valid_count", nv, 15);
      check("m2_accept", am, 15'h3c00);
      // idle ce without start produces nothing
      ce = 1'b1; start = 1'b0; data_in = 1'b1;
      @(posedge clk); #1;
      check("idle_no_valid", {data_out_valid, done, accept}, 0);
      ce = 1'b0;
      // all-zero message
      run_cw(5'b00000, 0, 15, cw, am, pm, dm, nv, gerr);
      check("zero_codeword", cw, 15'h0000);
      check("zero_done", dm, 15'h0001);
      check("zero_valid_count", nv, 15);
      // ce gaps give the same sequence
      run_cw(5'b00001, 1, 15, cw, am, pm, dm, nv, gerr);
      check("gap_codeword", cw, 15'h0537);
      check("gap_parity_flag", pm, 15'h03ff);
      check("gap_done", dm, 15'h0001);
      check("gap_quiet", gerr, 0);
      // abort after 4 parity bits, then a fresh codeword
      run_cw(5'b00001, 0, 9, cw, am, pm, dm, nv, gerr);
      check("abort_partial", cw, 15'h0014);
      check("abort_no_done", dm, 15'h0000);
      run_cw(5'b10000, 0, 15, cw, am, pm, dm, nv, gerr);
      check("after_abort_codeword", cw, 15'h429b);
      check("after_abort_done", dm, 15'h0001);
      // random messages: codeword is systematic and divisible by g(x)
      for (int k = 0; k < 20; k++) begin
         msg = 5'($urandom);
         run_cw(msg, 1, 15, cw, am, pm, dm, nv, gerr);
         check("rand_systematic", cw[14:10], msg);
         check("rand_syndrome_zero", mod15(cw), 0);
         check("rand_done", dm, 15'h0001);
      end
      // asynchronous reset mid-DATA
      ce = 1'b1; start = 1'b1; data_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_busy", {accept, data_out, data_out_valid}, 3'b111);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {accept, data_out, data_out_valid, parity_out, done}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", {accept, data_out_valid, done}, 0);
      ce = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bch_encode.md
# bch_encode

Serial systematic BCH encoder: the transmit-side counterpart of the serial syndrome calculator. It takes message bits one per enabled cycle, MSB (highest-degree coefficient) first, and forwards them unchanged. It then appends the PARITY_BITS remainder of m(x)·x^PARITY_BITS mod g(x), also MSB-first. The emitted bit order matches what bch_syndrome consumes, so an error-free codeword from this block yields all-zero syndromes.

## Interface
Parameters:
- DATA_BITS, 5: message bits per codeword (k).
- PARITY_BITS, 10: generator degree (n−k).
- GEN_POLY, 10'h137: generator coefficients x^(PARITY_BITS−1)..x^0; the leading x^PARITY_BITS term is implicit. Default is BCH(15,5), M=4, T=3: g = x^10+x^8+x^5+x^4+x^2+x+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  advance enable; nothing changes while low.
- start  input  1  with ce: data_in is the first message bit of a new codeword.
- data_in  input  1  message bit, sampled when ce=1 and (start=1 or state=DATA).
- accept  output  1  combinational; 1 when state=DATA, i.e. the next ce consumes data_in without start.
- data_out  output  1  registered codeword bit.
- data_out_valid  output  1  registered; 1 for the cycle after each ce that produced a codeword bit.
- parity_out  output  1  registered; 1 when data_out is a parity bit.
- done  output  1  registered one-cycle pulse with the last parity bit.

## Operation
- States: IDLE, DATA, PARITY. Bit counter cnt has width clog2(max(DATA_BITS, PARITY_BITS)). LFSR lfsr[PARITY_BITS−1:0].
- Feedback fb = data_in ^ lfsr[PARITY_BITS−1].
- ce=1 and start=1, accepted in any state (an in-flight codeword is abandoned, with no done):
  - lfsr ← GEN_POLY & {fb with lfsr treated as 0} = GEN_POLY & {PARITY_BITS{data_in}}.
  - data_out ← data_in; cnt ← 1.
  - State ← DATA, or ← PARITY directly if DATA_BITS==1.
- DATA, ce=1, start=0:
  - lfsr ← {lfsr[PARITY_BITS−2:0],0} ^ (GEN_POLY & {PARITY_BITS{fb}}).
  - data_out ← data_in; cnt++.
  - When cnt reaches DATA_BITS−1 before the increment, go to PARITY with cnt ← 0.
- PARITY, ce=1, start=0:
  - data_out ← lfsr[PARITY_BITS−1]; lfsr ← {lfsr[PARITY_BITS−2:0],0}; parity_out ← 1; cnt++.
  - On the PARITY_BITS-th bit: done ← 1, state ← IDLE.
  - data_in is ignored.
- IDLE, ce=1, start=0: no change; data_out_valid ← 0.
- ce=0: all registers hold, except data_out_valid and done, which clear to 0.
- parity_out ← 0 for any data-phase output bit.

## Timing
- Reset (async assert, released synchronously by the system) sets:
  - state=IDLE, lfsr=0, cnt=0
  - data_out=0, data_out_valid=0, parity_out=0, done=0
  - accept=0
- Latency: the codeword bit for a given ce cycle appears on data_out one clk later.
- Throughput: one bit per ce. A full codeword takes DATA_BITS+PARITY_BITS ce cycles.
- start may be asserted on the ce immediately after done's source cycle (the last parity ce). Codewords then stream back-to-back with no gap.
- Reset mid-codeword: the codeword is discarded and no done is produced.
- Gaps in ce anywhere in DATA or PARITY are legal and do not change the emitted sequence.

## Test plan
- Message 00001 with ce held high:
  - data_out sequence is 00001 then 0100110111 (parity 0x137).
  - parity_out is high for the last 10 bits; done pulses with the final 1.
- Message 10000: parity bits are 1010011011 (0x29B); full codeword is 100001010011011.
- All-zero message: 15 zero bits, then done.
- Back-to-back codewords:
  - 00001 then 10000 with start on the cycle after the last parity ce: 30 contiguous valid bits, two done pulses.
  - Random ce gaps (ce≈50%) give an identical bit sequence.
- Abort and reset:
  - start reasserted at parity bit 4: the old codeword is truncated with no done, and the new codeword is correct.
  - rst_n low mid-DATA: all outputs are 0 immediately, asynchronously.
- Closed loop: 1000 random messages feed bch_syndrome (M=4, T=3).
  - All syndromes are zero.
  - Flipping 1–3 random bits of each codeword gives nonzero syndromes.
